mips_mc_ctrl: RTL and testbench
===============================

# mips_mc_ctrl

- Multi-cycle MIPS control unit: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the shared datapath muxes, register file and a single handshaked instruction/data memory port.
- Adds a memory-wait watchdog, a sticky error state and a retired-instruction counter.
- Successor to the single-cycle decoder; sits between the instruction register and the multi-cycle datapath.

## Interface

Parameters:
- WAIT_W, 8, width of memory-wait counter
- MAX_WAIT, 255, wait cycles tolerated before bus error; 0 disables timeout
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_wr  out  1  write request (qualifies mem_req)
- iord  out  1  address mux: 0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A
- reg_write  out  1  register file write
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate << 2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = immediate op
- instr_done  out  1  one-cycle pulse when an instruction retires
- bus_err  out  1  sticky watchdog error
- ill_instr  out  1  sticky illegal-opcode error
- instret  out  CNT_W  retired instructions, saturating
- state  out  4  current state, for debug

## Operation

- Reset: state = FETCH, counters = 0, error flags = 0.
- All outputs are decoded from state except pc_write, ir_write and instr_done.
- Signals not listed for a state are 0.
- States (encoding), asserted signals and next state:
  - FETCH(0): mem_req, alu_src_b = 01, ir_write = pc_write = mem_ready. Next: DECODE on mem_ready.
  - DECODE(1): alu_src_b = 11. Next by opcode:
    - lw (23h) or sw (2Bh) → MEMADR
    - op 00h, funct 08h → JR
    - op 00h, funct 09h → JALR (only with macro)
    - other op 00h → EXEC
    - 08h, 0Ch, 0Dh, 0Eh, 0Ah → IEXEC
    - 04h → BRANCH
    - 02h → JUMP
    - 03h → JAL
    - anything else → ERR with ill_instr = 1
  - MEMADR(2): alu_src_a, alu_src_b = 10. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD(3): mem_req, iord. Next: MEMWB on mem_ready.
  - MEMWB(4): reg_write, mem_to_reg = 01, reg_dst = 00. Next: FETCH.
  - MEMWR(5): mem_req, mem_wr, iord. Next: FETCH on mem_ready.
  - EXEC(6): alu_src_a, alu_op = 10. Next: ALUWB.
  - ALUWB(7): reg_write, reg_dst = 01. Next: FETCH.
  - IEXEC(8): alu_src_a, alu_src_b = 10, alu_op = 11. Next: IWB.
  - IWB(9): reg_write, reg_dst = 00. Next: FETCH.
  - BRANCH(10): alu_src_a, alu_op = 01, pc_src = 01, pc_write = zero. Next: FETCH.
  - JUMP(11): pc_src = 10, pc_write. Next: FETCH.
  - JAL(12): pc_src = 10, pc_write, reg_write, reg_dst = 10, mem_to_reg = 10. Next: FETCH.
  - JR(13): pc_src = 11, pc_write. Next: FETCH.
  - JALR(14): pc_src = 11, pc_write, reg_write, reg_dst = 01, mem_to_reg = 10. Next: FETCH.
  - ERR(15): all datapath outputs 0. Absorbing; only rst_n exits.
- instr_done pulses in every state whose next state is FETCH. In MEMWR it pulses only on mem_ready.
- instret increments on instr_done and saturates at all ones.
- Watchdog:
  - wait_cnt increments each cycle mem_req = 1 and mem_ready = 0.
  - It clears on any state change.
  - If MAX_WAIT ≠ 0 and wait_cnt == MAX_WAIT with mem_ready = 0: next state = ERR, bus_err = 1.
  - mem_ready arriving in that same cycle wins; no error is raised.
- Asserting rst_n low mid-instruction aborts immediately. No write strobe is asserted during or after reset.

## Timing

- Latency with zero-wait memory (mem_ready = 1 on request):
  - lw: 5 cycles
  - sw, R-type, I-type: 4 cycles
  - beq, j, jal, jr, jalr: 3 cycles
- Each memory wait cycle adds 1 cycle.
- JAL/JALR write PC (already PC+4) to the register file on the same edge the PC is loaded.
- Status outputs change on the clock edge after the triggering condition:
  - ERR entry, bus_err and ill_instr
  - instret, one cycle after instr_done

## Configuration

- MIPS_MC_JALR_EN defined:
  - op 00h / funct 09h → JALR state (14); rd ← PC, PC ← A.
- Undefined:
  - op 00h / funct 09h → ERR with ill_instr = 1.
  - State 14 is unreachable.

## Test plan

- Reset, then lw (op 23h) with mem_ready tied 1 → states 0,1,2,3,4,0; reg_write and mem_to_reg = 01 in cycle 5; instr_done once; instret = 1.
- sw with mem_ready low for 3 cycles in MEMWR → mem_req, mem_wr and iord held 3 cycles; FETCH on the 4th; total 7 cycles.
- beq with zero = 0 then zero = 1 → pc_write low then high in BRANCH, with pc_src = 01.
- MAX_WAIT = 4, mem_ready held 0 in FETCH → ERR after 5 cycles; bus_err = 1; outputs stay 0 until rst_n.
- op 3Fh → ERR, ill_instr = 1. op 00h/funct 09h → JALR with macro, ERR without.
- rst_n pulsed low during MEMRD → state = 0, all flags and counters = 0; next cycle mem_req = 1 with iord = 0.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// ============================================================================
// mips_mc_ctrl
// ----------------------------------------------------------------------------
// Multi-cycle MIPS control unit. It steps each instruction through fetch,
// decode, execute, memory and writeback. From the current state it drives the
// shared datapath muxes, the register file write and one handshaked
// instruction/data memory port. It also provides a memory-wait watchdog,
// sticky bus and illegal-instruction error flags, and a saturating counter of
// retired instructions.
//
// Optional feature macro: MIPS_MC_JALR_EN
//   defined   : op 00h / funct 09h (jalr) executes in the JALR state
//   undefined : op 00h / funct 09h is illegal (ERR, ill_instr set)
//
// Parameters:
//   WAIT_W    width of the memory-wait counter
//   MAX_WAIT  wait cycles tolerated before a bus error (0 = no timeout)
//   CNT_W     width of the retired-instruction counter
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   op, funct         instruction register fields IR[31:26], IR[5:0]
//   zero              ALU zero flag (branch condition)
//   mem_ready         memory completes the current request this cycle
//   mem_req, mem_wr   memory request, and its write qualifier
//   iord              address mux: 0 = PC, 1 = ALUOut
//   ir_write          load instruction register
//   pc_write, pc_src  PC load enable and source select
//   reg_write         register file write enable
//   reg_dst           write register: 00 rt, 01 rd, 10 $31
//   mem_to_reg        write data: 00 ALUOut, 01 MDR, 10 PC
//   alu_src_a/_b      ALU operand selects
//   alu_op            00 add, 01 sub, 10 funct, 11 immediate op
//   instr_done        one-cycle pulse when an instruction retires
//   bus_err           sticky watchdog error
//   ill_instr         sticky illegal-opcode error
//   instret           retired-instruction count (saturating)
//   state             current FSM state, for debug
// ============================================================================
module mips_mc_ctrl #(
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             instr_done,
    output logic             bus_err,
    output logic             ill_instr,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_JALR   = 4'd14,
        S_ERR    = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               bus_err_q, bus_err_d;
    logic               ill_q, ill_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    logic               memPhase;
    logic               waiting;
    logic               timeout;
    logic               decodeIllegal;

    // A memory request is outstanding only in the three memory states.
    // The watchdog fires when the wait budget is used up and memory still
    // has not answered; a mem_ready in that same cycle wins.
    always_comb begin
        memPhase = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        waiting  = memPhase && !mem_ready;
        timeout  = (MAX_WAIT != 0) && waiting && (wait_q == WAIT_LIMIT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Decode dispatches on the opcode; an unknown opcode
    // parks the FSM in ERR, which only reset can leave.
    always_comb begin
        state_d       = state_q;
        decodeIllegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            state_d = S_JR;
                        end else if (funct == FN_JALR) begin
`ifdef MIPS_MC_JALR_EN
                            state_d = S_JALR;
`else
                            state_d       = S_ERR;
                            decodeIllegal = 1'b1;
`endif
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = S_IEXEC;
                    OP_BEQ: state_d = S_BRANCH;
                    OP_J:   state_d = S_JUMP;
                    OP_JAL: state_d = S_JAL;
                    default: begin
                        state_d       = S_ERR;
                        decodeIllegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_JAL:    state_d = S_FETCH;
            S_JR:     state_d = S_FETCH;
            S_JALR:   state_d = S_FETCH;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_ERR;
        endcase
        if (timeout) state_d = S_ERR;
    end

    // Output decode. Almost everything is a pure function of state; only
    // ir_write/pc_write (fetch handshake, branch condition) and instr_done
    // (store completion) also look at inputs. Write strobes are forced low
    // while reset is asserted so nothing is written during reset.
    always_comb begin
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                mem_wr     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                instr_done = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
            end
            S_JR: begin
                pc_src     = 2'b11;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_JALR: begin
                pc_src     = 2'b11;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            mem_wr     = 1'b0;
            instr_done = 1'b0;
        end
    end

    // Status next-values: the wait counter restarts on every state change
    // and saturates rather than wrapping when the timeout is disabled; the
    // error flags are sticky; instret saturates at all ones.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting && (wait_q != '1)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        bus_err_d = bus_err_q | timeout;
        ill_d     = ill_q | (decodeIllegal && !timeout);
        instret_d = instret_q;
        if (instr_done && (instret_q != '1)) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            ill_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            ill_q     <= ill_d;
            instret_q <= instret_d;
        end
    end

    assign bus_err   = bus_err_q;
    assign ill_instr = ill_q;
    assign instret   = instret_q;
    assign state     = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// ============================================================================
// tb_mips_mc_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for mips_mc_ctrl. The DUT is built with MAX_WAIT = 4 so
// the watchdog trips quickly, and with CNT_W = 3 so the instret saturation
// at 7 is reached after a handful of instructions. Expected control vectors
// are written out by hand for every state visited.
// ============================================================================
module tb_mips_mc_ctrl;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       op = 6'h00;
    logic [5:0]       funct = 6'h00;
    logic             zero = 1'b0;
    logic             memReady = 1'b0;

    logic             memReq, memWr, iord, irWrite, pcWrite;
    logic [1:0]       pcSrc;
    logic             regWrite;
    logic [1:0]       regDst, memToReg;
    logic             aluSrcA;
    logic [1:0]       aluSrcB, aluOp;
    logic             instrDone, busErr, illInstr;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state;
    logic [17:0]      ctlBus;

    int checkCount = 0;
    int errorCount = 0;

    mips_mc_ctrl #(
        .WAIT_W  (8),
        .MAX_WAIT(4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (memReady),
        .mem_req   (memReq),
        .mem_wr    (memWr),
        .iord      (iord),
        .ir_write  (irWrite),
        .pc_write  (pcWrite),
        .pc_src    (pcSrc),
        .reg_write (regWrite),
        .reg_dst   (regDst),
        .mem_to_reg(memToReg),
        .alu_src_a (aluSrcA),
        .alu_src_b (aluSrcB),
        .alu_op    (aluOp),
        .instr_done(instrDone),
        .bus_err   (busErr),
        .ill_instr (illInstr),
        .instret   (instret),
        .state     (state)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // All datapath controls packed in one vector so a single comparison
    // also proves that unlisted signals are 0.
    assign ctlBus = {memReq, memWr, iord, irWrite, pcWrite, pcSrc, regWrite,
                     regDst, memToReg, aluSrcA, aluSrcB, aluOp, instrDone};

    function automatic logic [17:0] mkCtl(input int mReq, input int mWr, input int io,
                                          input int irW, input int pcW, input int pcS,
                                          input int rW, input int rDst, input int m2r,
                                          input int aA, input int aB, input int aOp,
                                          input int iDone);
        return {1'(mReq), 1'(mWr), 1'(io), 1'(irW), 1'(pcW), 2'(pcS), 1'(rW),
                2'(rDst), 2'(m2r), 1'(aA), 2'(aB), 2'(aOp), 1'(iDone)};
    endfunction

    // The one comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int opV, input int functV, input int zeroV,
                                 input int readyV);
        op       = 6'(opV);
        funct    = 6'(functV);
        zero     = 1'(zeroV);
        memReady = 1'(readyV);
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCycle(input string tag, input int st, input logic [17:0] ctl);
        checkOutput({tag, ".state"}, 32'(state), 32'(st));
        checkOutput({tag, ".ctl"}, 32'(ctlBus), 32'(ctl));
    endtask

    task automatic checkStatus(input string tag, input int cnt, input int bErr,
                               input int ill);
        checkOutput({tag, ".instret"}, 32'(instret), 32'(cnt));
        checkOutput({tag, ".bus_err"}, 32'(busErr), 32'(bErr));
        checkOutput({tag, ".ill_instr"}, 32'(illInstr), 32'(ill));
    endtask

    // Fetch (zero-wait) and decode of one instruction; returns in the
    // third state with the instruction fields still applied.
    task automatic fetchDecode(input string tag, input int opV, input int functV,
                               input int zeroV);
        applyStimulus(opV, functV, zeroV, 1);
        checkCycle({tag, ".fetch"}, 0, mkCtl(1,0,0,1,1,0,0,0,0,0,1,0,0));
        stepCycle();
        checkCycle({tag, ".decode"}, 1, mkCtl(0,0,0,0,0,0,0,0,0,0,3,0,0));
        stepCycle();
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkOutput({tag, ".state"}, 32'(state), 32'd0);
        checkStatus(tag, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        // Reset with mem_ready high: FETCH decode visible, strobes held low.
        applyStimulus(0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        checkCycle("reset", 0, mkCtl(1,0,0,0,0,0,0,0,0,0,1,0,0));
        checkStatus("reset", 0, 0, 0);
        rst_n = 1'b1;

        // lw, zero-wait: 0,1,2,3,4,0.
        fetchDecode("lw", 6'h23, 0, 0);
        checkCycle("lw.memadr", 2, mkCtl(0,0,0,0,0,0,0,0,0,1,2,0,0));
        stepCycle();
        checkCycle("lw.memrd", 3, mkCtl(1,0,1,0,0,0,0,0,0,0,0,0,0));
        checkOutput("lw.memrd.instret", 32'(instret), 32'd0);
        stepCycle();
        checkCycle("lw.memwb", 4, mkCtl(0,0,0,0,0,0,1,0,1,0,0,0,1));
        stepCycle();
        checkOutput("lw.end.state", 32'(state), 32'd0);
        checkStatus("lw.end", 1, 0, 0);

        // sw with three wait cycles in MEMWR.
        fetchDecode("sw", 6'h2B, 0, 0);
        checkCycle("sw.memadr", 2, mkCtl(0,0,0,0,0,0,0,0,0,1,2,0,0));
        stepCycle();
        applyStimulus(6'h2B, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checkCycle($sformatf("sw.wait%0d", i), 5, mkCtl(1,1,1,0,0,0,0,0,0,0,0,0,0));
            stepCycle();
        end
        applyStimulus(6'h2B, 0, 0, 1);
        checkCycle("sw.ready", 5, mkCtl(1,1,1,0,0,0,0,0,0,0,0,0,1));
        stepCycle();
        checkOutput("sw.end.state", 32'(state), 32'd0);
        checkStatus("sw.end", 2, 0, 0);

        // beq not taken, then taken.
        for (int z = 0; z < 2; z++) begin
            fetchDecode($sformatf("beq%0d", z), 6'h04, 0, z);
            checkCycle($sformatf("beq%0d.branch", z), 10, mkCtl(0,0,0,0,z,1,0,0,0,1,0,1,1));
            stepCycle();
        end
        checkStatus("beq.end", 4, 0, 0);

        // R-type add.
        fetchDecode("rtype", 6'h00, 6'h20, 0);
        checkCycle("rtype.exec", 6, mkCtl(0,0,0,0,0,0,0,0,0,1,0,2,0));
        stepCycle();
        checkCycle("rtype.aluwb", 7, mkCtl(0,0,0,0,0,0,1,1,0,0,0,0,1));
        stepCycle();
        checkStatus("rtype.end", 5, 0, 0);

        // ori.
        fetchDecode("ori", 6'h0D, 0, 0);
        checkCycle("ori.iexec", 8, mkCtl(0,0,0,0,0,0,0,0,0,1,2,3,0));
        stepCycle();
        checkCycle("ori.iwb", 9, mkCtl(0,0,0,0,0,0,1,0,0,0,0,0,1));
        stepCycle();
        checkStatus("ori.end", 6, 0, 0);

        // jal, jr, j: counter reaches 7 and then saturates.
        fetchDecode("jal", 6'h03, 0, 0);
        checkCycle("jal.exec", 12, mkCtl(0,0,0,0,1,2,1,2,2,0,0,0,1));
        stepCycle();
        checkStatus("jal.end", 7, 0, 0);
        fetchDecode("jr", 6'h00, 6'h08, 0);
        checkCycle("jr.exec", 13, mkCtl(0,0,0,0,1,3,0,0,0,0,0,0,1));
        stepCycle();
        checkStatus("jr.end", 7, 0, 0);
        fetchDecode("j", 6'h02, 0, 0);
        checkCycle("j.exec", 11, mkCtl(0,0,0,0,1,2,0,0,0,0,0,0,1));
        stepCycle();
        checkStatus("j.end", 7, 0, 0);

        // mem_ready arriving on the last tolerated wait cycle wins,
        // then an illegal opcode lands in ERR.
        applyStimulus(6'h3F, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checkCycle($sformatf("race.wait%0d", i), 0, mkCtl(1,0,0,0,0,0,0,0,0,0,1,0,0));
            stepCycle();
        end
        applyStimulus(6'h3F, 0, 0, 1);
        checkCycle("race.ready", 0, mkCtl(1,0,0,1,1,0,0,0,0,0,1,0,0));
        stepCycle();
        checkOutput("race.decode.state", 32'(state), 32'd1);
        checkOutput("race.bus_err", 32'(busErr), 32'd0);
        checkOutput("ill.pre", 32'(illInstr), 32'd0);
        stepCycle();
        checkCycle("ill.err", 15, mkCtl(0,0,0,0,0,0,0,0,0,0,0,0,0));
        checkStatus("ill.err", 7, 0, 1);
        doReset("ill.rst");

        // Watchdog: five unanswered FETCH cycles, then ERR.
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkCycle($sformatf("wdog.wait%0d", i), 0, mkCtl(1,0,0,0,0,0,0,0,0,0,1,0,0));
            checkOutput($sformatf("wdog.wait%0d.bus_err", i), 32'(busErr), 32'd0);
            stepCycle();
        end
        checkCycle("wdog.err", 15, mkCtl(0,0,0,0,0,0,0,0,0,0,0,0,0));
        checkStatus("wdog.err", 0, 1, 0);
        applyStimulus(6'h23, 0, 1, 1);
        stepCycle();
        stepCycle();
        checkCycle("wdog.stuck", 15, mkCtl(0,0,0,0,0,0,0,0,0,0,0,0,0));
        checkOutput("wdog.stuck.bus_err", 32'(busErr), 32'd1);
        doReset("wdog.rst");

        // jalr: own state with the macro, illegal without it.
        fetchDecode("jalr", 6'h00, 6'h09, 0);
`ifdef MIPS_MC_JALR_EN
        checkCycle("jalr.exec", 14, mkCtl(0,0,0,0,1,3,1,1,2,0,0,0,1));
        stepCycle();
        checkStatus("jalr.end", 1, 0, 0);
`else
        checkCycle("jalr.err", 15, mkCtl(0,0,0,0,0,0,0,0,0,0,0,0,0));
        checkStatus("jalr.err", 0, 0, 1);
`endif
        doReset("jalr.rst");

        // Reset in the middle of a load clears everything.
        fetchDecode("pre", 6'h02, 0, 0);
        stepCycle();
        checkStatus("pre.end", 1, 0, 0);
        fetchDecode("abort", 6'h23, 0, 0);
        stepCycle();
        applyStimulus(6'h23, 0, 0, 0);
        checkCycle("abort.memrd", 3, mkCtl(1,0,1,0,0,0,0,0,0,0,0,0,0));
        rst_n = 1'b0;
        applyStimulus(6'h23, 0, 0, 1);
        checkCycle("abort.inrst", 0, mkCtl(1,0,0,0,0,0,0,0,0,0,1,0,0));
        checkStatus("abort.inrst", 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0);
        stepCycle();
        checkCycle("abort.after", 0, mkCtl(1,0,0,0,0,0,0,0,0,0,1,0,0));
        checkStatus("abort.after", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
